// File: rtl/imem_boot_arbiter.sv
// Boots the CPU from a loader-filled single-port imem, then shares that imem between CPU fetch and the loader.
// Optional perf counters (stall_cnt, fetch_cnt) are built when IMEM_BOOT_ARB_PERF_EN is defined.
module imem_boot_arbiter #(
  parameter int          ADDR_W   = 11,
  parameter logic [31:0] BASE     = 32'h00400000,
  parameter int          MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [31:0]       cpu_pc,
  output logic [31:0]       cpu_instr,
  output logic              cpu_valid,
  output logic              cpu_stall,
  output logic              cpu_rst,
  output logic              addr_err,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [31:0]       ld_rdata,
  input  logic              ld_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef IMEM_BOOT_ARB_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fetch_cnt
`endif
);

  typedef enum logic [1:0] {S_LOAD, S_RELEASE, S_RUN} state_e;

  localparam int          WCNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [32:0] SPAN   = 33'(4) << ADDR_W;

  state_e            state_q;
  logic              cpu_rst_q, addr_err_q, cpu_valid_q, fetch_oor_q, ld_rvalid_q;
  logic [WCNT_W-1:0] wait_q, wait_d;

  logic [31:0] pc_off;
  logic        in_range, ld_force, fetch_go;

  // Offset compare avoids overflow of BASE + span near the top of the address space.
  assign pc_off   = cpu_pc - BASE;
  assign in_range = (cpu_pc >= BASE) && ({1'b0, pc_off} < SPAN);

  always_comb begin
    ld_gnt    = 1'b0;
    ld_force  = 1'b0;
    fetch_go  = 1'b0;
    cpu_stall = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wait_d    = '0;
    case (state_q)
      S_LOAD: ld_gnt = ld_req;
      S_RUN: begin
        ld_force  = ld_req && (wait_q == WCNT_W'(MAX_WAIT));
        ld_gnt    = ld_req && (!cpu_req || ld_force);
        cpu_stall = cpu_req && ld_force;
        fetch_go  = cpu_req && !ld_force;
        if (ld_req && !ld_gnt)
          wait_d = (wait_q == WCNT_W'(MAX_WAIT)) ? wait_q : wait_q + WCNT_W'(1);
      end
      default: wait_d = '0;
    endcase
    if (ld_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end else if (fetch_go && in_range) begin
      mem_en   = 1'b1;
      mem_addr = pc_off[ADDR_W+1:2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      cpu_rst_q   <= 1'b1;
      addr_err_q  <= 1'b0;
      cpu_valid_q <= 1'b0;
      fetch_oor_q <= 1'b0;
      ld_rvalid_q <= 1'b0;
      wait_q      <= '0;
    end else begin
      wait_q      <= wait_d;
      cpu_valid_q <= fetch_go;
      fetch_oor_q <= fetch_go && !in_range;
      ld_rvalid_q <= ld_gnt && !ld_we;
      if (fetch_go && !in_range)
        addr_err_q <= 1'b1;
      case (state_q)
        S_LOAD:    if (ld_done) state_q <= S_RELEASE;
        S_RELEASE: begin
          cpu_rst_q <= 1'b0;
          state_q   <= S_RUN;
        end
        S_RUN:     state_q <= S_RUN;
        default:   state_q <= S_LOAD;
      endcase
    end
  end

  // Out-of-range fetches complete with a NOP instead of stale memory data.
  assign cpu_instr = fetch_oor_q ? 32'h0 : mem_rdata;
  assign cpu_valid = cpu_valid_q;
  assign cpu_rst   = cpu_rst_q;
  assign addr_err  = addr_err_q;
  assign ld_rvalid = ld_rvalid_q;
  assign ld_rdata  = mem_rdata;

`ifdef IMEM_BOOT_ARB_PERF_EN
  logic [31:0] stall_cnt_q, fetch_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fetch_cnt_q <= '0;
    end else if (state_q == S_RUN) begin
      if (cpu_stall)   stall_cnt_q <= stall_cnt_q + 32'd1;
      if (cpu_valid_q) fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Directed bench for imem_boot_arbiter: boot, fetch, range errors, loader starvation, idle sharing, reset mid-read.
module tb_imem_boot_arbiter;

  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req;
  logic [31:0]       cpu_pc;
  logic [31:0]       cpu_instr;
  logic              cpu_valid, cpu_stall, cpu_rst, addr_err;
  logic              ld_req, ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_wdata;
  logic              ld_gnt, ld_rvalid;
  logic [31:0]       ld_rdata;
  logic              ld_done;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
`ifdef IMEM_BOOT_ARB_PERF_EN
  logic [31:0]       stall_cnt, fetch_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_boot_arbiter #(.ADDR_W(ADDR_W), .BASE(32'h00400000), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_pc(cpu_pc), .cpu_instr(cpu_instr), .cpu_valid(cpu_valid),
    .cpu_stall(cpu_stall), .cpu_rst(cpu_rst), .addr_err(addr_err),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_done(ld_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef IMEM_BOOT_ARB_PERF_EN
    , .stall_cnt(stall_cnt), .fetch_cnt(fetch_cnt)
`endif
  );

  // Single-port synchronous imem with 1-cycle read latency.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_pc = '0; ld_req = 1'b0; ld_we = 1'b0;
    ld_addr = '0; ld_wdata = '0; ld_done = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    check("rst_cpu_valid", 32'(cpu_valid), 32'd0);
    check("rst_ld_gnt", 32'(ld_gnt), 32'd0);
    check("rst_ld_rvalid", 32'(ld_rvalid), 32'd0);
    check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    tick();

    // Boot: two loader writes, ld_done concurrent with the second; fetch requests ignored.
    rst = 1'b0; cpu_req = 1'b1; cpu_pc = 32'h00400000;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 11'd0; ld_wdata = 32'h24010005;
    @(negedge clk);
    check("load_gnt0", 32'(ld_gnt), 32'd1);
    check("load_we0", 32'(mem_we), 32'd1);
    check("load_stall", 32'(cpu_stall), 32'd0);
    tick();
    ld_addr = 11'd1; ld_wdata = 32'h24020007; ld_done = 1'b1;
    @(negedge clk);
    check("load_gnt_done", 32'(ld_gnt), 32'd1);
    check("load_addr1", 32'(mem_addr), 32'd1);
    check("load_cpu_rst", 32'(cpu_rst), 32'd1);
    check("load_cpu_valid", 32'(cpu_valid), 32'd0);
    tick();
    ld_req = 1'b0; ld_done = 1'b0;
    @(negedge clk);
    check("release_cpu_rst", 32'(cpu_rst), 32'd1);
    check("release_mem_en", 32'(mem_en), 32'd0);
    tick();

    // Fetch word 1.
    cpu_pc = 32'h00400004;
    @(negedge clk);
    check("run_cpu_rst", 32'(cpu_rst), 32'd0);
    check("fetch_mem_en", 32'(mem_en), 32'd1);
    check("fetch_mem_addr", 32'(mem_addr), 32'd1);
    tick();
    cpu_pc = 32'h003FFFFC;
    @(negedge clk);
    check("fetch_valid", 32'(cpu_valid), 32'd1);
    check("fetch_instr", cpu_instr, 32'h24020007);
    check("oor_lo_mem_en", 32'(mem_en), 32'd0);
    check("oor_lo_err_pre", 32'(addr_err), 32'd0);
    tick();
    cpu_pc = 32'h00402000;
    @(negedge clk);
    check("oor_lo_valid", 32'(cpu_valid), 32'd1);
    check("oor_lo_instr", cpu_instr, 32'h0);
    check("oor_lo_err", 32'(addr_err), 32'd1);
    check("oor_hi_mem_en", 32'(mem_en), 32'd0);
    tick();

    // Starvation guard: loader read forced through on the 9th request cycle.
    cpu_pc = 32'h00400000; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 11'd0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("oor_hi_instr", cpu_instr, 32'h0);
        check("oor_hi_err", 32'(addr_err), 32'd1);
      end
      check($sformatf("starve_gnt%0d", i), 32'(ld_gnt), 32'(i == 9));
      check($sformatf("starve_stall%0d", i), 32'(cpu_stall), 32'(i == 9));
      tick();
    end
    ld_req = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    check("starve_rvalid", 32'(ld_rvalid), 32'd1);
    check("starve_rdata", ld_rdata, 32'h24010005);
    check("starve_no_fetch", 32'(cpu_valid), 32'd0);
    check("starve_stall_end", 32'(cpu_stall), 32'd0);
    check("err_sticky", 32'(addr_err), 32'd1);
    tick();

    // Idle share: loader write while CPU idle, then fetch it back.
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 11'd5; ld_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("idle_gnt", 32'(ld_gnt), 32'd1);
    check("idle_stall", 32'(cpu_stall), 32'd0);
    check("idle_we", 32'(mem_we), 32'd1);
    tick();
    ld_req = 1'b0; ld_we = 1'b0; cpu_req = 1'b1; cpu_pc = 32'h00400014;
    @(negedge clk);
    check("idle_fetch_addr", 32'(mem_addr), 32'd5);
    check("idle_no_rvalid", 32'(ld_rvalid), 32'd0);
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    check("idle_fetch_valid", 32'(cpu_valid), 32'd1);
    check("idle_fetch_instr", cpu_instr, 32'hDEADBEEF);
    check("idle_no_rvalid2", 32'(ld_rvalid), 32'd0);
    tick();

    // Reset during a loader read grant: read is dropped.
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 11'd0; rst = 1'b1;
    @(negedge clk);
    check("rstrd_gnt", 32'(ld_gnt), 32'd1);
    tick();
    rst = 1'b0; ld_req = 1'b0; cpu_req = 1'b1; cpu_pc = 32'h00400000;
    @(negedge clk);
    check("rstrd_no_rvalid", 32'(ld_rvalid), 32'd0);
    check("rstrd_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rstrd_addr_err", 32'(addr_err), 32'd0);
    check("rstrd_load_no_fetch", 32'(mem_en), 32'd0);
    tick();
    @(negedge clk);
    check("rstrd_no_valid", 32'(cpu_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
